// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and default size.
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Counts shift edges and strobes word_valid on the edge that completes a WIDTH-bit word.
module shift_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  output logic [CNT_W-1:0] bit_count,
  output logic             word_valid
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             valid_reg;
  logic             valid_next;

  always_comb begin
    count_next = count_reg;
    valid_next = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (shift_en) begin
      // Wrap and strobe together so the strobe lines up with the completed word.
      if (count_reg == LAST_COUNT) begin
        count_next = '0;
        valid_next = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      valid_reg <= valid_next;
    end
  end

  assign bit_count  = count_reg;
  assign word_valid = valid_reg;

endmodule

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load) with word counter.
// Optional rotate input enabled by defining SHIFT_REG_ROTATE_EN.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             data_in,
  input  logic [0:WIDTH-1] load_data,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic             serial_data_out,
  output logic [0:WIDTH-1] parallel_data_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             word_valid
);

  mode_t            mode_sel;
  logic [0:WIDTH-1] data_reg;
  logic [0:WIDTH-1] data_next;
  logic [0:WIDTH-1] shr_vec;
  logic [0:WIDTH-1] shl_vec;
  logic             shr_in;
  logic             shl_in;
  logic             shift_en;
  logic             load_en;

  assign mode_sel = mode_t'(mode);

`ifdef SHIFT_REG_ROTATE_EN
  assign shr_in = rotate ? data_reg[WIDTH-1] : data_in;
  assign shl_in = rotate ? data_reg[0]       : data_in;
`else
  assign shr_in = data_in;
  assign shl_in = data_in;
`endif

  // Index 0 is the "head" end: SHR feeds it, SHL drains toward it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == 0) begin : g_first
      assign shr_vec[gi] = shr_in;
    end else begin : g_rest
      assign shr_vec[gi] = data_reg[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_last
      assign shl_vec[gi] = shl_in;
    end else begin : g_body
      assign shl_vec[gi] = data_reg[gi+1];
    end
  end

  always_comb begin
    data_next = data_reg;
    case (mode_sel)
      MODE_SHR:  data_next = shr_vec;
      MODE_SHL:  data_next = shl_vec;
      MODE_LOAD: data_next = load_data;
      default:   data_next = data_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign shift_en = (mode_sel == MODE_SHR) || (mode_sel == MODE_SHL);
  assign load_en  = (mode_sel == MODE_LOAD);

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (shift_en),
    .clear      (load_en),
    .bit_count  (bit_count),
    .word_valid (word_valid)
  );

  assign serial_data_out   = (mode_sel == MODE_SHL) ? data_reg[0] : data_reg[WIDTH-1];
  assign parallel_data_out = data_reg;

endmodule
